// File: rtl/ps2_kbmat.sv
// PS/2 set-2 keyboard receiver that maintains the Z88 64-key pressed matrix (1 = pressed).
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames must also pass the odd-parity check.
module ps2_kbmat #(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned TO_W           = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2clk,
   input  logic        ps2dat,
   output logic [63:0] kbmat_out,
   output logic        rx_strobe,
   output logic [7:0]  rx_data,
   output logic        rx_error
);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_nxt;

   logic             clk_s1, clk_s2, clk_q, dat_s1, dat_s2;
   logic             fall_c, timeout_c, parity_ok_c;
   logic             start_c, shift_c, frame_ok_c, frame_bad_c;
   logic [CNT_W-1:0] bit_cnt;
   logic [7:0]       shreg;
   logic [TO_W-1:0]  to_cnt;
   logic             e0_flag, f0_flag;
   logic             map_hit_c;
   logic [5:0]       map_idx_c;

   // Two-flop synchronisers; clk_q holds the previous synchronised ps2clk for edge detect
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_q  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2clk;
         clk_s2 <= clk_s1;
         clk_q  <= clk_s2;
         dat_s1 <= ps2dat;
         dat_s2 <= dat_s1;
      end
   end

   assign fall_c    = clk_q & ~clk_s2;
   assign timeout_c = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
   logic par_bit;

   always_ff @(posedge clk) begin
      if (!reset_n)
         par_bit <= 1'b0;
      else if (fall_c && (state == PARITY))
         par_bit <= dat_s2;
   end

   assign parity_ok_c = ^{shreg, par_bit};
`else
   assign parity_ok_c = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (timeout_c) begin
         state_nxt = IDLE;
      end else if (fall_c) begin
         case (state)
            IDLE:    if (!dat_s2) state_nxt = DATA;
            DATA:    if (bit_cnt == CNT_W'(7)) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      start_c     = 1'b0;
      shift_c     = 1'b0;
      frame_ok_c  = 1'b0;
      frame_bad_c = 1'b0;
      if (fall_c && !timeout_c) begin
         case (state)
            IDLE:    start_c = ~dat_s2;
            DATA:    shift_c = 1'b1;
            STOP: begin
               frame_ok_c  = dat_s2 & parity_ok_c;
               frame_bad_c = ~(dat_s2 & parity_ok_c);
            end
            default: ;
         endcase
      end
   end

   // Receive datapath, byte/error reporting and frame timeout
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         to_cnt    <= '0;
         rx_strobe <= 1'b0;
         rx_data   <= '0;
         rx_error  <= 1'b0;
      end else begin
         rx_strobe <= frame_ok_c;
         rx_error  <= frame_bad_c | timeout_c;
         if (frame_ok_c)
            rx_data <= shreg;
         if (start_c)
            bit_cnt <= '0;
         else if (shift_c)
            bit_cnt <= bit_cnt + CNT_W'(1);
         if (shift_c)
            shreg <= {dat_s2, shreg[7:1]};
         if ((state == IDLE) || fall_c || timeout_c)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TO_W'(1);
      end
   end

   // Keymap ROM: {E0 prefix, scan code} -> matrix index (8*row + col)
   always_comb begin
      map_hit_c = 1'b1;
      map_idx_c = 6'd0;
      case ({e0_flag, rx_data})
         9'h03E: map_idx_c = 6'd0;   9'h03D: map_idx_c = 6'd1;
         9'h031: map_idx_c = 6'd2;   9'h175: map_idx_c = 6'd3;
         9'h172: map_idx_c = 6'd4;   9'h036: map_idx_c = 6'd5;
         9'h05A: map_idx_c = 6'd6;   9'h066: map_idx_c = 6'd7;
         9'h046: map_idx_c = 6'd8;   9'h02E: map_idx_c = 6'd9;
         9'h03A: map_idx_c = 6'd10;  9'h033: map_idx_c = 6'd11;
         9'h035: map_idx_c = 6'd12;  9'h03B: map_idx_c = 6'd13;
         9'h03C: map_idx_c = 6'd14;  9'h045: map_idx_c = 6'd15;
         9'h025: map_idx_c = 6'd16;  9'h041: map_idx_c = 6'd17;
         9'h042: map_idx_c = 6'd18;  9'h034: map_idx_c = 6'd19;
         9'h02C: map_idx_c = 6'd20;  9'h043: map_idx_c = 6'd21;
         9'h044: map_idx_c = 6'd22;  9'h04D: map_idx_c = 6'd23;
         9'h026: map_idx_c = 6'd24;  9'h049: map_idx_c = 6'd25;
         9'h04B: map_idx_c = 6'd26;  9'h02B: map_idx_c = 6'd27;
         9'h02D: map_idx_c = 6'd28;  9'h04E: map_idx_c = 6'd29;
         9'h04C: map_idx_c = 6'd30;  9'h054: map_idx_c = 6'd31;
         9'h01E: map_idx_c = 6'd32;  9'h04A: map_idx_c = 6'd33;
         9'h032: map_idx_c = 6'd34;  9'h023: map_idx_c = 6'd35;
         9'h024: map_idx_c = 6'd36;  9'h055: map_idx_c = 6'd37;
         9'h052: map_idx_c = 6'd38;  9'h05B: map_idx_c = 6'd39;
         9'h016: map_idx_c = 6'd40;  9'h02A: map_idx_c = 6'd41;
         9'h021: map_idx_c = 6'd42;  9'h01C: map_idx_c = 6'd43;
         9'h01D: map_idx_c = 6'd44;  9'h00D: map_idx_c = 6'd45;
         9'h05D: map_idx_c = 6'd46;  9'h00E: map_idx_c = 6'd47;
         9'h015: map_idx_c = 6'd48;  9'h022: map_idx_c = 6'd49;
         9'h01B: map_idx_c = 6'd50;  9'h01A: map_idx_c = 6'd51;
         9'h058: map_idx_c = 6'd52;  9'h029: map_idx_c = 6'd53;
         9'h012: map_idx_c = 6'd54;  9'h014: map_idx_c = 6'd55;
         9'h16B: map_idx_c = 6'd56;  9'h174: map_idx_c = 6'd57;
         9'h011: map_idx_c = 6'd58;  9'h005: map_idx_c = 6'd59;
         9'h006: map_idx_c = 6'd60;  9'h076: map_idx_c = 6'd61;
         9'h171: map_idx_c = 6'd62;  9'h059: map_idx_c = 6'd63;
         default: map_hit_c = 1'b0;
      endcase
   end

   // Make/break decoder; acts on the registered byte so the matrix updates one cycle later
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         kbmat_out <= '0;
         e0_flag   <= 1'b0;
         f0_flag   <= 1'b0;
      end else if (rx_error) begin
         e0_flag <= 1'b0;
         f0_flag <= 1'b0;
      end else if (rx_strobe) begin
         case (rx_data)
            8'hE0: e0_flag <= 1'b1;
            8'hF0: f0_flag <= 1'b1;
            8'hAA, 8'h00, 8'hFF: begin
               kbmat_out <= '0;
               e0_flag   <= 1'b0;
               f0_flag   <= 1'b0;
            end
            default: begin
               if (map_hit_c)
                  kbmat_out[map_idx_c] <= ~f0_flag;
               e0_flag <= 1'b0;
               f0_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbmat.sv
// Bench for ps2_kbmat: scoreboard of expected received bytes/errors plus explicit key-matrix expectations.
// Honours PS2_PARITY_CHECK_EN the same way as the design.
module tb_ps2_kbmat;
   localparam int unsigned TIMEOUT_CYCLES = 20000;
   localparam int unsigned HALF           = 20;

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2clk  = 1'b1;
   logic        ps2dat  = 1'b1;
   logic [63:0] kbmat_out;
   logic        rx_strobe;
   logic [7:0]  rx_data;
   logic        rx_error;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_mat = '0;

   ps2_kbmat #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(15)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2clk    (ps2clk),
      .ps2dat    (ps2dat),
      .kbmat_out (kbmat_out),
      .rx_strobe (rx_strobe),
      .rx_data   (rx_data),
      .rx_error  (rx_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive the first nbits bits of a frame: start, 8 data LSB first, parity, stop
   task automatic ps2_bits(input logic [7:0] b, input logic par_inv, input logic stop_bit,
                           input int nbits);
      logic [10:0] f;
      f = {stop_bit, (~^b) ^ par_inv, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2dat = f[i];
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2clk = 1'b1;
      end
      ps2dat = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      sb.push_back('{err: 1'b0, data: b});
      ps2_bits(b, 1'b0, 1'b1, 11);
      repeat (10) @(negedge clk);
   endtask

   // Scoreboard monitor: every strobe/error pulse must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n && (rx_strobe || rx_error)) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", {62'd0, rx_error, rx_strobe}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.err)
               chk("rx_error", {62'd0, rx_error, rx_strobe}, 64'd2);
            else
               chk("rx_byte", {54'd0, rx_error, rx_strobe, rx_data}, {54'd0, 1'b0, 1'b1, mon_e.data});
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_kbmat", kbmat_out, 64'd0);
      chk("rst_strobe", {63'd0, rx_strobe}, 64'd0);
      chk("rst_error", {63'd0, rx_error}, 64'd0);
      chk("rst_data", {56'd0, rx_data}, 64'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Make A with exact latency from the stop-bit falling edge
      sb.push_back('{err: 1'b0, data: 8'h1C});
      ps2_bits(8'h1C, 1'b0, 1'b1, 10);
      ps2dat = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2clk = 1'b0;
      repeat (3) @(negedge clk);
      chk("lat_strobe", {63'd0, rx_strobe}, 64'd1);
      chk("lat_mat_pre", {63'd0, kbmat_out[43]}, 64'd0);
      @(negedge clk);
      chk("lat_mat", {63'd0, kbmat_out[43]}, 64'd1);
      repeat (HALF - 4) @(negedge clk);
      ps2clk = 1'b1;
      repeat (10) @(negedge clk);
      exp_mat[43] = 1'b1;
      chk("make_a", kbmat_out, exp_mat);

      // Invalid frame between F0 and a make must drop the F0 prefix
      send(8'hF0);
      sb.push_back('{err: 1'b1, data: 8'h00});
      ps2_bits(8'h33, 1'b0, 1'b0, 11);
      repeat (10) @(negedge clk);
      send(8'h1C);
      chk("badstop_flags", kbmat_out, exp_mat);
      send(8'hF0); send(8'h1C);
      exp_mat[43] = 1'b0;
      chk("break_a", kbmat_out, exp_mat);

      // Extended keys
      send(8'hE0); send(8'h75);
      exp_mat[3] = 1'b1;
      chk("make_up", kbmat_out, exp_mat);
      send(8'h75);
      chk("plain_75_miss", kbmat_out, exp_mat);
      send(8'hE0); send(8'hF0); send(8'h75);
      exp_mat[3] = 1'b0;
      chk("break_up", kbmat_out, exp_mat);
      send(8'hE0);
      repeat (300) @(negedge clk);
      send(8'h72);
      exp_mat[4] = 1'b1;
      chk("e0_persist", kbmat_out, exp_mat);
      send(8'hE0); send(8'hF0); send(8'h72);
      exp_mat[4] = 1'b0;
      chk("break_down", kbmat_out, exp_mat);

      // Enter with inverted parity
`ifdef PS2_PARITY_CHECK_EN
      sb.push_back('{err: 1'b1, data: 8'h00});
`else
      sb.push_back('{err: 1'b0, data: 8'h5A});
      exp_mat[6] = 1'b1;
`endif
      ps2_bits(8'h5A, 1'b1, 1'b1, 11);
      repeat (10) @(negedge clk);
      chk("bad_parity", kbmat_out, exp_mat);
      send(8'hF0); send(8'h5A);
      send(8'hF0); send(8'h5A);
      exp_mat[6] = 1'b0;
      chk("break_enter", kbmat_out, exp_mat);

      // Left/right shift independence and BAT reset
      send(8'h12); send(8'h59); send(8'h59);
      exp_mat[54] = 1'b1;
      exp_mat[63] = 1'b1;
      chk("both_shift", kbmat_out, exp_mat);
      send(8'hF0); send(8'h12);
      exp_mat[54] = 1'b0;
      chk("lshift_rel", kbmat_out, exp_mat);
      send(8'hAA);
      exp_mat = '0;
      chk("bat_clear", kbmat_out, exp_mat);

      // Partial frame abandoned by timeout, then a good frame
      sb.push_back('{err: 1'b1, data: 8'h00});
      ps2_bits(8'h00, 1'b0, 1'b1, 5);
      repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
      chk("timeout_drained", 64'(sb.size()), 64'd0);
      send(8'h29);
      exp_mat[53] = 1'b1;
      chk("after_timeout", kbmat_out, exp_mat);
      send(8'h76);
      exp_mat[61] = 1'b1;
      chk("make_esc", kbmat_out, exp_mat);
      send(8'hFF);
      exp_mat = '0;
      chk("overrun_clear", kbmat_out, exp_mat);

      // Reset in the middle of a frame, with A pressed and E0 pending
      send(8'h1C);
      exp_mat[43] = 1'b1;
      chk("make_a2", kbmat_out, exp_mat);
      send(8'hE0);
      ps2_bits(8'h76, 1'b0, 1'b1, 4);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_kbmat", kbmat_out, 64'd0);
      chk("mid_rst_strobe", {63'd0, rx_strobe}, 64'd0);
      chk("mid_rst_error", {63'd0, rx_error}, 64'd0);
      chk("mid_rst_data", {56'd0, rx_data}, 64'd0);
      reset_n = 1'b1;
      exp_mat = '0;
      repeat (5) @(negedge clk);
      send(8'h75);
      chk("rst_clears_e0", kbmat_out, exp_mat);
      send(8'h76);
      exp_mat[61] = 1'b1;
      chk("esc_after_rst", kbmat_out, exp_mat);

      repeat (20) @(negedge clk);
      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_kbmat.md
Name: ps2_kbmat

Overview:
- PS/2 keyboard front end that sits directly upstream of the Z88 top level; its 64-bit output feeds the matrix the Blink keyboard read decodes on address lines A8..A15.
- Receives PS/2 device-to-host frames and decodes set-2 make/break codes, including the E0 and F0 prefixes.
- Maintains a 64-bit pressed-key matrix, one bit per Z88 key, with 1 meaning pressed.
- Runs entirely on the system clock clk; ps2clk and ps2dat are asynchronous inputs.

Parameters:
TIMEOUT_CYCLES, 20000, number of clk cycles without a ps2clk falling edge after which a partial frame is abandoned.
TO_W, 15, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock.
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
ps2clk  input  1  PS/2 clock, asynchronous.
ps2dat  input  1  PS/2 data, asynchronous.
kbmat_out  output  64  pressed-key matrix; bit index = 8*row + col, where row n is the key line selected by address bit A(8+n).
rx_strobe  output  1  one-cycle pulse when a valid byte is received.
rx_data  output  8  last valid byte; held until the next valid byte.
rx_error  output  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset (reset_n=0 at a clk edge): kbmat_out=0, rx_strobe=0, rx_data=0, rx_error=0, FSM in IDLE, bit count 0, E0 and F0 flags cleared, timeout counter 0. Reset has priority over everything, including a frame in progress.
- Synchronisation: ps2clk and ps2dat each pass through a 2-flop synchroniser. A falling edge is detected as synchronised previous=1 and current=0. ps2dat is sampled on that detect cycle (cycle F).
- Receive FSM:
  - IDLE: on a falling edge with dat=0 (start bit), go to DATA with count 0. A falling edge with dat=1 is ignored and no error is raised.
  - DATA: shift dat into bit[count], LSB first. After 8 bits, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: on a falling edge, go to IDLE. The frame is valid if dat=1 and the odd-parity check passes (see Optional Feature).
  - Valid frame: rx_strobe=1 and rx_data=byte at F+1.
  - Invalid frame: rx_error=1 at F+1, no decode, E0 and F0 flags cleared.
- Timeout: in any state other than IDLE, the counter increments every clk and resets to 0 on each falling edge. When it reaches TIMEOUT_CYCLES: return to IDLE, rx_error pulse, flags cleared. The counter is held at 0 in IDLE.
- Decoder (acts at F+1, so kbmat_out changes at F+2 and is registered):
  - 0xE0: set E0.
  - 0xF0: set F0.
  - 0xAA (BAT OK), 0x00 or 0xFF (overrun): kbmat_out=0, flags cleared.
  - Any other byte: look up {E0,byte} in the keymap. On a hit, kbmat_out[idx] = ~F0. A miss is ignored. Both flags are cleared in either case.
  - A repeated make for a key already pressed leaves it set; a break for a key not pressed leaves it clear.
- Keymap: 64 entries, combinational ROM, defined in the keymap section of the keyboard design note. Entries the bench relies on:
  - 0x1C A -> 43
  - 0x5A Enter -> 6
  - 0x29 Space -> 53
  - 0x76 Esc -> 61
  - 0x12 LShift -> 54
  - 0x59 RShift -> 63
  - E0 0x75 Up -> 3
  - E0 0x72 Down -> 4
- Timing and ordering:
  - A byte decode and a falling edge in the same cycle are independent and both take effect.
  - Flags persist between bytes with no time limit.
  - Left and right shift are separate bits; releasing one does not affect the other.

Optional Feature:
PS2_PARITY_CHECK_EN:
- Defined: a frame is valid only when the XOR of the 8 data bits and the parity bit is 1. A frame failing this check produces an rx_error pulse and is dropped.
- Undefined: the parity bit is shifted and ignored; only the start bit and stop bit determine validity.

Test Plan:
- Reset values: hold reset_n=0 for 3 clk -> kbmat_out=0, rx_strobe=0, rx_error=0, rx_data=0x00.
- Make/break of A: send frame 0x1C -> rx_strobe with rx_data=0x1C, and kbmat_out[43]=1 two clk after the stop edge. Then send F0,1C -> kbmat_out[43]=0 and all other bits 0.
- Extended key: send E0,75 -> kbmat_out[3]=1. Send 75 alone -> no change, since it is a keymap miss without the E0 prefix. Send E0,F0,75 -> kbmat_out[3]=0.
- Bad parity: send 0x5A with the parity bit inverted -> with PS2_PARITY_CHECK_EN, rx_error pulses and kbmat_out[6] stays 0; without it, kbmat_out[6]=1.
- Timeout: send the start bit plus 4 data bits, then stop clocking for TIMEOUT_CYCLES+2 -> rx_error pulse. A following complete 0x29 frame -> kbmat_out[53]=1.
- Overrun and mid-frame reset: with Space and Esc pressed, send 0xFF -> kbmat_out=0. Assert reset_n mid-frame -> all outputs return to reset values. The next complete 0x76 frame -> kbmat_out[61]=1.
